pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Hazard controller for the 5-stage pipeline (IF, ID, EXE, MEM, WB).
- Keeps its own shadow of the EXE, MEM and WB stage occupants.
- Generates the stall (interlock), flush and forwarding-select signals that sequence the IF2ID, ID2EXE and EXE2MEM registers.
- Keeps saturating stall and flush event counters for performance visibility.

Parameters:
REG_ADDR_W, 5, register address width
FORWARD_EN, 1, 1 = forwarding mode (stall only where forwarding cannot cover); 0 = pure interlock mode (fwd outputs held 00)
CNT_W, 16, width of the event counters

Ports:
clock  in  1  system clock; all state updates on the rising edge
reset  in  1  asynchronous, active-high reset
id_valid  in  1  IF2ID holds a real instruction
id_rs  in  REG_ADDR_W  source register 1 of the ID instruction
id_rt  in  REG_ADDR_W  source register 2 of the ID instruction
id_use_rs  in  1  ID instruction reads rs
id_use_rt  in  1  ID instruction reads rt
id_reg_write  in  1  ID instruction writes the register file
id_mem_read  in  1  ID instruction is a load
id_dest  in  REG_ADDR_W  resolved destination register (rt/rd already selected)
mem_branch_taken  in  1  Branch & Zero for the instruction in MEM
stall  out  1  hold PC and IF2ID; load a bubble into ID2EXE
flush  out  1  invalidate IF2ID, ID2EXE and EXE2MEM at the next edge
fwd_a  out  2  ALU operand A source for the EXE instruction: 00 = regfile, 10 = EXE2MEM ALU result, 01 = WB write data
fwd_b  out  2  same encoding, for ALU operand B / store data
stall_count  out  CNT_W  stall cycles; saturating
flush_count  out  CNT_W  flush events; saturating

Behaviour:
- Shadow stage state for EX, MEM and WB: v, rw, mr, dest. EX additionally holds rs, rt, use_rs, use_rt.
- Reset (async): all v = 0, counters = 0. Resulting outputs: stall = 0, flush = 0, fwd_a = fwd_b = 00.
- Outputs are combinational from shadow state and ID inputs; decisions take effect at the same edge.
- match(S, r) = S.v & S.rw & (S.dest == r) & (r != 0). Register 0 never creates a hazard or forward.
- dep(S) = (id_use_rs & match(S, id_rs)) | (id_use_rt & match(S, id_rt)).
- flush = mem_branch_taken & MEM.v.
- Stall condition, FORWARD_EN = 1: id_valid & ~flush & ((dep(EX) & EX.mr) | dep(WB)).
  - The regfile has no write-through, so a WB-stage writer always costs one stall.
- Stall condition, FORWARD_EN = 0: id_valid & ~flush & (dep(EX) | dep(MEM) | dep(WB)).
- Flush has priority: stall is forced to 0 when flush = 1.
- fwd_a, FORWARD_EN = 1: 10 if EX.use_rs & match(MEM, EX.rs) & ~MEM.mr; else 01 if EX.use_rs & match(WB, EX.rs); else 00. MEM has priority over WB.
- fwd_b: same rule using EX.rt and EX.use_rt.
- Load in MEM with a dependent in EX cannot occur, because the load-use stall prevents it.
- fwd_a and fwd_b are 00 whenever EX.v = 0, and constant 00 when FORWARD_EN = 0.
- Per-edge state update:
  - flush: EX <= bubble, MEM <= bubble, WB <= MEM.
  - else if stall: EX <= bubble, MEM <= EX, WB <= MEM.
  - else: EX <= ID fields with v = id_valid, MEM <= EX, WB <= MEM.
- Bubble = v 0; other fields are don't-care.
- Counters:
  - stall_count += 1 on each edge where stall = 1.
  - flush_count += 1 on each edge where flush = 1.
  - Both hold at all-ones (saturate, no wrap).
- Reset asserted mid-stall or mid-flush: all outputs drop to their reset values immediately, without waiting for a clock edge.

Test Plan:
- Back-to-back ALU, FORWARD_EN = 1: add r3 then sub using rs = 3 → stall never 1; fwd_a = 10 in the dependent's EXE cycle. A second consumer at distance 2 → fwd_a = 01.
- Load-use: lw r2 in EX, ID uses rt = 2 → stall = 1 for exactly one cycle, stall_count = 1. In the dependent's EXE cycle, fwd_b = 01.
- Distance 3: writer of r5 in WB while a reader of r5 is in ID → one stall cycle, then fwd = 00.
- FORWARD_EN = 0, distance-1 dependency → stall = 1 for 3 consecutive cycles, fwd held 00, stall_count = 3.
- Branch taken: MEM.v = 1 and mem_branch_taken = 1 while a load-use condition is also present → flush = 1, stall = 0, flush_count = 1. Next cycle EX.v = 0 and MEM.v = 0.
- Register-0 destination with a dependent reader → no stall, fwd = 00.
- Reset asserted during a stall cycle → stall = 0 before the next edge; counters read 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: shadows EX/MEM/WB occupants and
// produces stall, flush and ALU operand forwarding selects plus event counters.

module pipe_hazard_fwd_lane #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  ex_v,
    input  logic                  use_src,
    input  logic [REG_ADDR_W-1:0] src,
    input  logic                  mem_v,
    input  logic                  mem_rw,
    input  logic                  mem_mr,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic                  wb_v,
    input  logic                  wb_rw,
    input  logic [REG_ADDR_W-1:0] wb_dest,
    output logic [1:0]            sel
);
    logic mem_hit, wb_hit;

    always_comb begin
        mem_hit = mem_v & mem_rw & (mem_dest == src) & (src != '0);
        wb_hit  = wb_v  & wb_rw  & (wb_dest  == src) & (src != '0);
        sel     = 2'b00;
        // A load in MEM has no result yet; the load-use stall keeps that case out.
        if (ex_v && use_src) begin
            if (mem_hit && !mem_mr) sel = 2'b10;
            else if (wb_hit)        sel = 2'b01;
        end
    end
endmodule

module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int FORWARD_EN = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_use_rs,
    input  logic                  id_use_rt,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  mem_branch_taken,
    output logic                  stall,
    output logic                  flush,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);
    localparam int STAGES  = 3;   // vld_pipe[1]=EX, [2]=MEM, [3]=WB
    localparam int NUM_OPS = 2;   // operand A (rs), operand B (rt)

    typedef struct packed {
        logic                  rw;
        logic [REG_ADDR_W-1:0] dest;
    } wr_t;

    typedef struct packed {
        wr_t                   wr;
        logic                  mr;
        logic                  use_rs;
        logic                  use_rt;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
    } ex_t;

    logic [STAGES:1] vld_pipe;
    ex_t             ex_q;
    wr_t             mem_wr_q, wb_wr_q;
    logic            mem_mr_q;

    function automatic logic hit(input logic v, input wr_t s, input logic [REG_ADDR_W-1:0] r);
        return v & s.rw & (s.dest == r) & (r != '0);
    endfunction

    logic dep_ex, dep_mem, dep_wb, hazard;

    always_comb begin
        dep_ex  = (id_use_rs & hit(vld_pipe[1], ex_q.wr, id_rs)) |
                  (id_use_rt & hit(vld_pipe[1], ex_q.wr, id_rt));
        dep_mem = (id_use_rs & hit(vld_pipe[2], mem_wr_q, id_rs)) |
                  (id_use_rt & hit(vld_pipe[2], mem_wr_q, id_rt));
        dep_wb  = (id_use_rs & hit(vld_pipe[3], wb_wr_q, id_rs)) |
                  (id_use_rt & hit(vld_pipe[3], wb_wr_q, id_rt));
        // No regfile write-through, so a WB producer always costs a cycle.
        hazard  = (FORWARD_EN != 0) ? ((dep_ex & ex_q.mr) | dep_wb)
                                    : (dep_ex | dep_mem | dep_wb);
        flush   = mem_branch_taken & vld_pipe[2];
        stall   = id_valid & ~flush & hazard;
    end

    logic [NUM_OPS-1:0][REG_ADDR_W-1:0] op_src;
    logic [NUM_OPS-1:0]                 op_use;
    logic [NUM_OPS-1:0][1:0]            op_sel;

    assign op_src = {ex_q.rt, ex_q.rs};
    assign op_use = {ex_q.use_rt, ex_q.use_rs};

    genvar g;
    generate
        for (g = 0; g < NUM_OPS; g++) begin : g_op
            pipe_hazard_fwd_lane #(.REG_ADDR_W(REG_ADDR_W)) u_lane (
                .ex_v     (vld_pipe[1]),
                .use_src  (op_use[g]),
                .src      (op_src[g]),
                .mem_v    (vld_pipe[2]),
                .mem_rw   (mem_wr_q.rw),
                .mem_mr   (mem_mr_q),
                .mem_dest (mem_wr_q.dest),
                .wb_v     (vld_pipe[3]),
                .wb_rw    (wb_wr_q.rw),
                .wb_dest  (wb_wr_q.dest),
                .sel      (op_sel[g])
            );
        end
    endgenerate

    assign fwd_a = (FORWARD_EN != 0) ? op_sel[0] : 2'b00;
    assign fwd_b = (FORWARD_EN != 0) ? op_sel[1] : 2'b00;

    // Payload always advances; only the valid bits encode bubbles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            ex_q     <= '0;
            mem_wr_q <= '0;
            mem_mr_q <= 1'b0;
            wb_wr_q  <= '0;
        end else begin
            ex_q     <= '{wr: '{rw: id_reg_write, dest: id_dest}, mr: id_mem_read,
                          use_rs: id_use_rs, use_rt: id_use_rt, rs: id_rs, rt: id_rt};
            mem_wr_q <= ex_q.wr;
            mem_mr_q <= ex_q.mr;
            wb_wr_q  <= mem_wr_q;
            vld_pipe[3] <= vld_pipe[2];
            if (flush)      vld_pipe[2:1] <= 2'b00;
            else if (stall) vld_pipe[2:1] <= {vld_pipe[1], 1'b0};
            else            vld_pipe[2:1] <= {vld_pipe[1], id_valid};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall && stall_count != '1) stall_count <= stall_count + CNT_W'(1);
            if (flush && flush_count != '1) flush_count <= flush_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench: forwarding (a) and interlock-only (b, 4-bit counters) controllers fed the
// same ID stream; directed scenarios plus random traffic against a stage-array model.

module tb_pipe_hazard_ctrl;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       id_valid, id_use_rs, id_use_rt, id_reg_write, id_mem_read, mem_branch_taken;
    logic [4:0] id_rs, id_rt, id_dest;

    logic        a_stall, a_flush;
    logic [1:0]  a_fwd_a, a_fwd_b;
    logic [15:0] a_stall_count, a_flush_count;
    logic        b_stall, b_flush;
    logic [1:0]  b_fwd_a, b_fwd_b;
    logic [3:0]  b_stall_count, b_flush_count;

    pipe_hazard_ctrl #(.REG_ADDR_W(5), .FORWARD_EN(1), .CNT_W(16)) dut_a (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_dest(id_dest), .mem_branch_taken(mem_branch_taken),
        .stall(a_stall), .flush(a_flush), .fwd_a(a_fwd_a), .fwd_b(a_fwd_b),
        .stall_count(a_stall_count), .flush_count(a_flush_count));

    pipe_hazard_ctrl #(.REG_ADDR_W(5), .FORWARD_EN(0), .CNT_W(4)) dut_b (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_dest(id_dest), .mem_branch_taken(mem_branch_taken),
        .stall(b_stall), .flush(b_flush), .fwd_a(b_fwd_a), .fwd_b(b_fwd_b),
        .stall_count(b_stall_count), .flush_count(b_flush_count));

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Model: per config, instructions in EX(0), MEM(1), WB(2). Config 0 = forwarding.
    typedef struct {
        bit v, rw, mr, urs, urt;
        int dest, rs, rt;
    } ins_t;

    ins_t pl[2][3];
    int   scnt[2], fcnt[2];
    int   cmax[2] = '{65535, 15};
    bit   st_now[2], fl_now[2];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit writes(int c, int s, int r);
        return pl[c][s].v && pl[c][s].rw && pl[c][s].dest == r && r != 0;
    endfunction

    function automatic bit id_needs(int c, int s);
        return (id_use_rs && writes(c, s, int'(id_rs))) || (id_use_rt && writes(c, s, int'(id_rt)));
    endfunction

    function automatic bit m_flush(int c);
        return mem_branch_taken && pl[c][1].v;
    endfunction

    function automatic bit m_stall(int c);
        bit h;
        if (c == 0) h = (id_needs(c, 0) && pl[c][0].mr) || id_needs(c, 2);
        else        h = id_needs(c, 0) || id_needs(c, 1) || id_needs(c, 2);
        return id_valid && !m_flush(c) && h;
    endfunction

    function automatic int m_fwd(int c, bit use_src, int r);
        if (c == 1 || !pl[c][0].v || !use_src) return 0;
        if (writes(c, 1, r) && !pl[c][1].mr) return 2;
        if (writes(c, 2, r)) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int s = 0; s < 3; s++) pl[c][s].v = 0;
            scnt[c] = 0;
            fcnt[c] = 0;
        end
    endtask

    task automatic model_check();
        for (int c = 0; c < 2; c++) begin
            st_now[c] = m_stall(c);
            fl_now[c] = m_flush(c);
            chk($sformatf("stall%0d", c), c == 0 ? 32'(a_stall) : 32'(b_stall), 32'(st_now[c]));
            chk($sformatf("flush%0d", c), c == 0 ? 32'(a_flush) : 32'(b_flush), 32'(fl_now[c]));
            chk($sformatf("fwd_a%0d", c), c == 0 ? 32'(a_fwd_a) : 32'(b_fwd_a),
                32'(m_fwd(c, pl[c][0].urs, pl[c][0].rs)));
            chk($sformatf("fwd_b%0d", c), c == 0 ? 32'(a_fwd_b) : 32'(b_fwd_b),
                32'(m_fwd(c, pl[c][0].urt, pl[c][0].rt)));
            chk($sformatf("stall_count%0d", c), c == 0 ? 32'(a_stall_count) : 32'(b_stall_count), 32'(scnt[c]));
            chk($sformatf("flush_count%0d", c), c == 0 ? 32'(a_flush_count) : 32'(b_flush_count), 32'(fcnt[c]));
        end
    endtask

    task automatic model_advance();
        ins_t id_ins, bub;
        id_ins = '{v: id_valid, rw: id_reg_write, mr: id_mem_read, urs: id_use_rs, urt: id_use_rt,
                   dest: int'(id_dest), rs: int'(id_rs), rt: int'(id_rt)};
        bub = id_ins;
        bub.v = 0;
        for (int c = 0; c < 2; c++) begin
            pl[c][2] = pl[c][1];
            pl[c][1] = fl_now[c] ? bub : pl[c][0];
            pl[c][0] = (fl_now[c] || st_now[c]) ? bub : id_ins;
            if (st_now[c] && scnt[c] < cmax[c]) scnt[c]++;
            if (fl_now[c] && fcnt[c] < cmax[c]) fcnt[c]++;
        end
    endtask

    task automatic drive(bit v, bit rw, bit mr, int dest, bit urs, int rs, bit urt, int rt, bit br);
        id_valid = v; id_reg_write = rw; id_mem_read = mr; id_dest = 5'(dest);
        id_use_rs = urs; id_rs = 5'(rs); id_use_rt = urt; id_rt = 5'(rt);
        mem_branch_taken = br;
        #1;
    endtask

    task automatic nop(bit br = 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, br);
    endtask

    task automatic cyc();
        model_check();
        @(posedge clock);
        model_advance();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        nop();
        chk("rst_stall", 32'({a_stall, b_stall}), 0);
        chk("rst_flush", 32'({a_flush, b_flush}), 0);
        chk("rst_fwd", 32'({a_fwd_a, a_fwd_b, b_fwd_a, b_fwd_b}), 0);
        chk("rst_cnt", 32'(a_stall_count) + 32'(a_flush_count) + 32'(b_stall_count) + 32'(b_flush_count), 0);
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        do_reset();

        // Back-to-back ALU: add r3, then readers at distance 1 and 2
        drive(1, 1, 0, 3, 0, 0, 0, 0, 0); cyc();
        drive(1, 1, 0, 4, 1, 3, 0, 0, 0);
        chk("alu_d1_nostall", 32'(a_stall), 0); cyc();
        drive(1, 1, 0, 5, 1, 3, 0, 0, 0);
        chk("alu_d1_fwd_a", 32'(a_fwd_a), 32'd2); cyc();
        nop();
        chk("alu_d2_fwd_a", 32'(a_fwd_a), 32'd1); cyc();
        nop(); cyc();

        // Load-use on rt
        do_reset();
        drive(1, 1, 1, 2, 0, 0, 0, 0, 0); cyc();
        drive(1, 1, 0, 7, 0, 0, 1, 2, 0);
        chk("lu_stall", 32'(a_stall), 1); cyc();
        drive(1, 1, 0, 7, 0, 0, 1, 2, 0);
        chk("lu_stall_once", 32'(a_stall), 0);
        chk("lu_count", 32'(a_stall_count), 1); cyc();
        nop();
        chk("lu_fwd_b", 32'(a_fwd_b), 32'd1); cyc();

        // Distance 3: writer of r5 in WB while reader in ID
        do_reset();
        drive(1, 1, 0, 5, 0, 0, 0, 0, 0); cyc();
        nop(); cyc();
        nop(); cyc();
        drive(1, 0, 0, 0, 1, 5, 0, 0, 0);
        chk("d3_stall", 32'(a_stall), 1); cyc();
        drive(1, 0, 0, 0, 1, 5, 0, 0, 0);
        chk("d3_release", 32'(a_stall), 0); cyc();
        nop();
        chk("d3_fwd", 32'(a_fwd_a), 0); cyc();

        // Interlock-only config: distance-1 dependency stalls three cycles
        do_reset();
        drive(1, 1, 0, 3, 0, 0, 0, 0, 0); cyc();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 1, 3, 0, 0, 0);
            chk($sformatf("il_stall%0d", i), 32'(b_stall), 1); cyc();
        end
        drive(1, 0, 0, 0, 1, 3, 0, 0, 0);
        chk("il_release", 32'(b_stall), 0);
        chk("il_count", 32'(b_stall_count), 3); cyc();
        nop();
        chk("il_fwd", 32'({b_fwd_a, b_fwd_b}), 0); cyc();

        // Taken branch in MEM beats a simultaneous load-use
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0); cyc();
        drive(1, 1, 1, 2, 0, 0, 0, 0, 0); cyc();
        drive(1, 0, 0, 0, 0, 0, 1, 2, 1);
        chk("br_flush", 32'(a_flush), 1);
        chk("br_nostall", 32'(a_stall), 0); cyc();
        drive(1, 0, 0, 0, 0, 0, 1, 2, 1);
        chk("br_count", 32'(a_flush_count), 1);
        chk("br_mem_empty", 32'(a_flush), 0);
        chk("br_ex_empty", 32'(a_stall), 0); cyc();

        // Register 0 destination never hazards or forwards
        do_reset();
        drive(1, 1, 1, 0, 0, 0, 0, 0, 0); cyc();
        drive(1, 1, 0, 0, 1, 0, 1, 0, 0);
        chk("r0_stall", 32'({a_stall, b_stall}), 0); cyc();
        nop();
        chk("r0_fwd", 32'({a_fwd_a, a_fwd_b}), 0); cyc();

        // Async reset in the middle of a WB-hazard stall with a nonzero count
        do_reset();
        drive(1, 1, 1, 2, 0, 0, 0, 0, 0); cyc();
        drive(1, 0, 0, 0, 0, 0, 1, 2, 0); cyc();
        nop(); cyc();
        drive(1, 0, 0, 0, 0, 0, 1, 2, 0);
        chk("mid_stall", 32'(a_stall), 1);
        chk("mid_count", 32'(a_stall_count), 1);
        reset = 1'b1;
        #1;
        chk("arst_stall", 32'(a_stall), 0);
        chk("arst_count", 32'(a_stall_count), 0);
        do_reset();

        // Random traffic over a small register set to keep hazards frequent
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                  int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)),
                  $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)), $urandom_range(0, 4) == 0);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
